// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//
// Monitors a multiplexed, active-low 7-segment display bus and rebuilds the
// BCD value shown on each digit. The block registers each bus sample and
// waits until the same select/pattern pair has been seen STABLE times in a
// row. It then decodes that pattern into the digit's working slot. When every
// slot has been captured, it publishes the whole frame at once.
//
// Parameters
//   DIGITS  number of multiplexed digits (1..8)
//   STABLE  consecutive identical samples needed for a capture (1..15)
//
// Ports
//   iClk         system clock, rising edge
//   iRst         asynchronous active-high reset
//   iSeg[6:0]    segment lines {g,f,e,d,c,b,a}, active-low
//   iAn          anode selects, active-low, bit i selects digit i
//   oDigits      last complete frame, digit i at [4i+3:4i]
//   oBlank       per-digit blank flags of the last frame
//   oErr         any digit of the last frame was undecodable
//   oFrameValid  one-cycle pulse when the frame outputs update
//   oAnErr       one-cycle pulse for a sample with more than one anode low

module seg7_scan_decoder #(
    parameter int DIGITS = 8,
    parameter int STABLE = 2
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [6:0]            iSeg,
    input  logic [DIGITS-1:0]     iAn,
    output logic [4*DIGITS-1:0]   oDigits,
    output logic [DIGITS-1:0]     oBlank,
    output logic                  oErr,
    output logic                  oFrameValid,
    output logic                  oAnErr
);

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    logic [6:0]        s_seg;
    logic [DIGITS-1:0] s_an;
    logic [6:0]        prev_seg;
    logic [DIGITS-1:0] prev_an;
    logic [3:0]        run_cnt;
    logic [3:0]        run_cnt_nxt;

    logic [DIGITS-1:0] sel;
    logic              is_idle;
    logic              is_multi;
    logic              is_valid;
    logic              same_sample;
    logic              capture;

    logic [3:0]        dec_code;
    logic              dec_blank;
    logic              dec_err;

    logic [3:0]        slot_code [DIGITS];
    logic [DIGITS-1:0] slot_blank;
    logic [DIGITS-1:0] slot_err;
    logic [DIGITS-1:0] fill;
    logic              frame_done;

    // Returns {err, blank, code[3:0]} for an active-low segment pattern.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] res;
        res = {2'b10, 4'hE};
        unique case (seg)
            7'b1000000: res = {2'b00, 4'd0};
            7'b1111001: res = {2'b00, 4'd1};
            7'b0100100: res = {2'b00, 4'd2};
            7'b0110000: res = {2'b00, 4'd3};
            7'b0011001: res = {2'b00, 4'd4};
            7'b0010010: res = {2'b00, 4'd5};
            7'b0000010: res = {2'b00, 4'd6};
            7'b1111000: res = {2'b00, 4'd7};
            7'b0000000: res = {2'b00, 4'd8};
            7'b0010000: res = {2'b00, 4'd9};
            7'b1111111: res = {2'b01, 4'hF};
            default:    res = {2'b10, 4'hE};
        endcase
        return res;
    endfunction

    // Active-high one-hot of the selected digit when the sample is valid.
    assign sel         = ~s_an;
    assign is_idle     = (sel == '0);
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign is_multi    = !is_idle && ((sel & (sel - DIGITS'(1))) != '0);
    assign is_valid    = !is_idle && !is_multi;
    assign same_sample = (s_seg == prev_seg) && (s_an == prev_an);
    assign frame_done  = &fill;

    always_comb begin
        run_cnt_nxt = 4'd0;
        if (is_valid) begin
            if (!same_sample) begin
                run_cnt_nxt = 4'd1;
            end else if (run_cnt == STABLE_C) begin
                run_cnt_nxt = run_cnt;
            end else begin
                run_cnt_nxt = run_cnt + 4'd1;
            end
        end
    end

    // Capture only on the transition into STABLE, so a long dwell produces
    // exactly one capture even though the counter saturates there.
    assign capture = is_valid && (run_cnt_nxt == STABLE_C)
                     && !(same_sample && (run_cnt == STABLE_C));

    assign {dec_err, dec_blank, dec_code} = decode_seg(s_seg);

    // Input stage and run qualification.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s_seg    <= '0;
            s_an     <= '1;
            prev_seg <= '0;
            prev_an  <= '1;
            run_cnt  <= 4'd0;
            oAnErr   <= 1'b0;
        end else begin
            s_seg    <= iSeg;
            s_an     <= iAn;
            prev_seg <= s_seg;
            prev_an  <= s_an;
            run_cnt  <= run_cnt_nxt;
            oAnErr   <= is_multi;
        end
    end

    // Working slots. When a frame is published, the fill mask and error flags
    // are cleared. A capture on that same edge still lands in its slot.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            fill       <= '0;
            slot_blank <= '0;
            slot_err   <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                slot_code[i] <= 4'd0;
            end
        end else begin
            fill <= (frame_done ? '0 : fill) | (capture ? sel : '0);
            for (int i = 0; i < DIGITS; i++) begin
                if (capture && sel[i]) begin
                    slot_code[i]  <= dec_code;
                    slot_blank[i] <= dec_blank;
                    slot_err[i]   <= dec_err;
                end else if (frame_done) begin
                    slot_err[i]   <= 1'b0;
                end
            end
        end
    end

    // Published frame; holds until the next complete frame.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oDigits     <= '1;
            oBlank      <= '0;
            oErr        <= 1'b0;
            oFrameValid <= 1'b0;
        end else begin
            oFrameValid <= frame_done;
            if (frame_done) begin
                for (int i = 0; i < DIGITS; i++) begin
                    oDigits[4*i +: 4] <= slot_code[i];
                end
                oBlank <= slot_blank;
                oErr   <= |slot_err;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

    localparam int DIGITS = 8;
    localparam int STABLE = 2;

    logic                 iClk = 1'b0;
    logic                 iRst;
    logic [6:0]           iSeg;
    logic [DIGITS-1:0]    iAn;
    logic [4*DIGITS-1:0]  oDigits;
    logic [DIGITS-1:0]    oBlank;
    logic                 oErr;
    logic                 oFrameValid;
    logic                 oAnErr;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .iClk(iClk), .iRst(iRst), .iSeg(iSeg), .iAn(iAn),
        .oDigits(oDigits), .oBlank(oBlank), .oErr(oErr),
        .oFrameValid(oFrameValid), .oAnErr(oAnErr)
    );

    always #5 iClk = ~iClk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    int n_cmp = 0;
    int n_bad = 0;
    int fv_seen = 0;
    int fv0;

    // Reference model: works on the raw input stream, counting how long each
    // identical valid sample persists and applying fixed pipeline latencies.
    logic [6:0]        m_prev_seg;
    logic [DIGITS-1:0] m_prev_an;
    int                m_run;
    logic [3:0]        m_code  [DIGITS];
    logic              m_blank [DIGITS];
    logic              m_err   [DIGITS];
    logic [DIGITS-1:0] m_fill;
    logic [31:0]       m_pub_d;
    logic [7:0]        m_pub_b;
    logic              m_pub_e;
    logic              stA_fv, stB_fv, stA_e, stB_e, anA;
    logic [31:0]       stA_d, stB_d;
    logic [7:0]        stA_b, stB_b;

    logic [6:0]        pats [DIGITS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [5:0] ref_decode(input logic [6:0] seg);
        for (int v = 0; v < 10; v++) begin
            if (seg_tab[v] == seg) return {2'b00, 4'(v)};
        end
        if (seg == 7'h7F) return {2'b01, 4'hF};
        return {2'b10, 4'hE};
    endfunction

    function automatic logic [DIGITS-1:0] sel_of(input int d);
        return ~(DIGITS'(1) << d);
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_prev_seg = '0;
        m_prev_an = '1;
        m_fill = '0;
        m_pub_d = '1;
        m_pub_b = '0;
        m_pub_e = 1'b0;
        stA_fv = 1'b0; stB_fv = 1'b0; anA = 1'b0;
        stA_d = '0; stB_d = '0; stA_b = '0; stB_b = '0; stA_e = 1'b0; stB_e = 1'b0;
    endtask

    task automatic model_capture(input int idx, input logic [6:0] seg);
        logic [5:0] r;
        r = ref_decode(seg);
        m_code[idx]  = r[3:0];
        m_blank[idx] = r[4];
        m_err[idx]   = r[5];
        m_fill[idx]  = 1'b1;
        if (m_fill == '1) begin
            stA_fv = 1'b1;
            stA_e  = 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                stA_d[4*i +: 4] = m_code[i];
                stA_b[i] = m_blank[i];
                stA_e = stA_e | m_err[i];
            end
            m_fill = '0;
        end
    endtask

    task automatic model_sample(input logic [6:0] seg, input logic [DIGITS-1:0] an);
        int zeros = 0;
        int idx = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an[i]) begin
                zeros++;
                idx = i;
            end
        end
        if (zeros == 1) begin
            if (seg == m_prev_seg && an == m_prev_an) m_run++;
            else m_run = 1;
            if (m_run == STABLE) model_capture(idx, seg);
        end else begin
            m_run = 0;
            if (zeros > 1) anA = 1'b1;
        end
        m_prev_seg = seg;
        m_prev_an = an;
    endtask

    task automatic step(input logic [6:0] seg, input logic [DIGITS-1:0] an);
        logic exp_fv, exp_an;
        iSeg = seg;
        iAn = an;
        @(posedge iClk);
        #1;
        exp_fv = stB_fv;
        if (stB_fv) begin
            m_pub_d = stB_d;
            m_pub_b = stB_b;
            m_pub_e = stB_e;
        end
        exp_an = anA;
        chk("frame_valid", 32'(oFrameValid), 32'(exp_fv));
        chk("an_err", 32'(oAnErr), 32'(exp_an));
        chk("digits", oDigits, m_pub_d);
        chk("blank", 32'(oBlank), 32'(m_pub_b));
        chk("err", 32'(oErr), 32'(m_pub_e));
        if (oFrameValid) fv_seen++;
        stB_fv = stA_fv; stB_d = stA_d; stB_b = stA_b; stB_e = stA_e;
        stA_fv = 1'b0;
        anA = 1'b0;
        model_sample(seg, an);
    endtask

    task automatic idle(input int n);
        repeat (n) step(7'h7F, '1);
    endtask

    task automatic scan(input int dwell);
        for (int d = 0; d < DIGITS; d++) begin
            repeat (dwell) step(pats[d], sel_of(d));
        end
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        #1;
        chk("rst_digits", oDigits, 32'hFFFF_FFFF);
        chk("rst_blank", 32'(oBlank), 32'h0);
        chk("rst_err", 32'(oErr), 32'h0);
        chk("rst_fv", 32'(oFrameValid), 32'h0);
        chk("rst_anerr", 32'(oAnErr), 32'h0);
        iAn = '1;
        iSeg = 7'h7F;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        model_reset();
    endtask

    initial begin
        iRst = 1'b1;
        iSeg = 7'h7F;
        iAn = '1;
        model_reset();
        do_reset();

        // Idle after reset: nothing captured or published.
        idle(50);
        chk("idle_no_frame", 32'(fv_seen), 32'd0);

        // Full scan of 0..7, twice.
        for (int d = 0; d < DIGITS; d++) pats[d] = seg_tab[d];
        scan(4);
        idle(3);
        chk("scan1_digits", oDigits, 32'h7654_3210);
        chk("scan1_err", 32'(oErr), 32'h0);
        chk("scan1_frames", 32'(fv_seen), 32'd1);
        scan(4);
        idle(3);
        chk("scan2_frames", 32'(fv_seen), 32'd2);

        // Blank and undecodable digits.
        for (int d = 0; d < DIGITS; d++) pats[d] = seg_tab[9];
        pats[3] = 7'b1111111;
        pats[5] = 7'b0101010;
        scan(3);
        idle(3);
        chk("bad_digits", oDigits, 32'h99E9_F999);
        chk("bad_blank", 32'(oBlank), 32'h08);
        chk("bad_err", 32'(oErr), 32'h1);

        // Glitch rejection: single-cycle dwells never capture.
        fv0 = fv_seen;
        for (int d = 0; d < DIGITS; d++) pats[d] = seg_tab[d];
        scan(1);
        scan(1);
        idle(3);
        chk("glitch_no_frame", 32'(fv_seen - fv0), 32'd0);
        for (int d = 0; d < DIGITS; d++) begin
            step(seg_tab[(d + 1) % 10], sel_of(d));
            repeat (2) step(seg_tab[9 - d], sel_of(d));
        end
        idle(3);
        chk("glitch_change", oDigits, 32'h2345_6789);

        // Anode fault: multi-low sample writes nothing.
        fv0 = fv_seen;
        for (int d = 0; d < DIGITS - 1; d++) repeat (2) step(seg_tab[1], sel_of(d));
        step(seg_tab[4], 8'hFC);
        chk("anerr_pulse", 32'(oAnErr), 32'h0);
        idle(1);
        chk("anerr_seen", 32'(oAnErr), 32'h1);
        idle(3);
        chk("anerr_no_frame", 32'(fv_seen - fv0), 32'd0);
        repeat (2) step(seg_tab[5], sel_of(7));
        idle(3);
        chk("anerr_frame", oDigits, 32'h5111_1111);

        // Reset mid-frame discards partial capture.
        for (int d = 0; d < 4; d++) repeat (3) step(seg_tab[8], sel_of(d));
        do_reset();
        fv0 = fv_seen;
        for (int d = 0; d < DIGITS; d++) pats[d] = seg_tab[d];
        scan(2);
        idle(3);
        chk("midrst_frames", 32'(fv_seen - fv0), 32'd1);
        chk("midrst_digits", oDigits, 32'h7654_3210);

        // Overwrite before completion.
        for (int d = 0; d < 4; d++) repeat (2) step(d == 2 ? seg_tab[3] : seg_tab[d], sel_of(d));
        repeat (2) step(seg_tab[8], sel_of(2));
        for (int d = 4; d < DIGITS; d++) repeat (2) step(seg_tab[d], sel_of(d));
        idle(3);
        chk("overwrite_slot2", 32'(oDigits[11:8]), 32'h8);
        chk("overwrite_digits", oDigits, 32'h7654_3810);

        // Randomized traffic against the model.
        for (int it = 0; it < 60; it++) begin
            int kind;
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                do_reset();
            end else if (kind < 3) begin
                step(7'($urandom), DIGITS'($urandom));
            end else if (kind < 5) begin
                idle($urandom_range(1, 4));
            end else begin
                for (int d = 0; d < DIGITS; d++) begin
                    int dig;
                    int dw;
                    logic [6:0] p;
                    dig = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DIGITS - 1)) : d;
                    p = ($urandom_range(0, 7) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 9)];
                    dw = $urandom_range(1, 4);
                    repeat (dw) step(p, sel_of(dig));
                end
            end
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the 7-segment display driver: it samples the multiplexed, active-low segment and anode lines the display driver produces and reconstructs the BCD value shown on each digit. Each digit pattern is qualified for stability, decoded back to 4 bits, and stored per digit. A complete frame is published once every digit has been captured. The block sits on the board-level display bus as an in-system monitor and as the self-checking end of display testbenches.

## Interface
- `DIGITS`, default 8: number of multiplexed digits; legal range 1..8.
- `STABLE`, default 2: consecutive identical samples required before a digit is captured; legal range 1..15.

- `iClk`  in  1: system clock; all state changes on the rising edge.
- `iRst`  in  1: reset, asynchronous and active-high; clears all state.
- `iSeg`  in  7: segment lines `{g,f,e,d,c,b,a}`, active-low (0 = lit).
- `iAn`  in  `DIGITS`: anode selects, active-low. Bit i low selects digit i.
- `oDigits`  out  `4*DIGITS`: last complete frame. Digit i is at `[4i+3:4i]`.
- `oBlank`  out  `DIGITS`: bit i = 1 when digit i was blank in the last frame.
- `oErr`  out  1: 1 when any digit in the last frame held an undecodable pattern.
- `oFrameValid`  out  1: one-cycle pulse when `oDigits`, `oBlank` and `oErr` update.
- `oAnErr`  out  1: one-cycle pulse when a registered `iAn` sample has more than one bit low.

## Operation
- **Input stage.** `iSeg` and `iAn` are registered once into `s_seg` and `s_an`. All qualification works on these registered values.
- **Sample classes.**
  - `s_an` all ones: idle. Run counter is cleared; no capture.
  - `s_an` with exactly one bit low: valid select. The slot index is the position of that low bit.
  - `s_an` with two or more bits low: `oAnErr` pulses the next cycle and the run counter clears.
- **Run counter.**
  - If the sample is a valid select and `{s_seg, s_an}` equals the previous sample, the run counter increments, saturating at `STABLE`.
  - If the sample is a valid select but differs from the previous sample, the run counter loads 1.
  - A capture occurs only on the cycle the counter reaches `STABLE`, so there is exactly one capture per dwell.
- **Decode table** (`iSeg` value → code):
  - 1000000 → 0; 1111001 → 1; 0100100 → 2; 0110000 → 3; 0011001 → 4
  - 0010010 → 5; 0000010 → 6; 1111000 → 7; 0000000 → 8; 0010000 → 9
  - 1111111 → code F, blank flag set
  - any other pattern → code E, error flag set
- **Capture.**
  - Writes the code, blank flag and error flag into the working slot.
  - Sets that slot's bit in the fill mask.
  - Capturing a slot that is already filled overwrites it; the fill mask is unchanged.
- **Frame completion.**
  - When a capture leaves the fill mask all ones, the next edge copies all working slots into `oDigits` and `oBlank`.
  - `oErr` is set to the OR of all slot error flags at that same edge.
  - `oFrameValid` is high for that one cycle.
  - The fill mask and working error flags clear at that same edge.
- **Frame output stability.** Frame outputs hold between `oFrameValid` pulses. Partial frames are never published.
- **Reset values** (also applied immediately on `iRst` mid-operation):
  - `oDigits` = all ones (F per digit); `oBlank` = 0; `oErr` = 0; `oFrameValid` = 0; `oAnErr` = 0.
  - Fill mask, run counter and sample registers all clear. Any in-progress frame is discarded.
- **Start after reset.** The first registered sample is compared against a cleared previous sample (`an` all ones), so it always starts a new run.

## Timing
- Input held constant from edge t through edge t+STABLE-1 (STABLE edges), with a valid select:
  - registered at edge t;
  - captured into the working slot at edge t+STABLE.
- Completing capture at edge c → frame outputs and `oFrameValid` at edge c+1. `oFrameValid` deasserts at c+2 unless another frame completes.
- Multi-low `iAn` sampled at edge t → `oAnErr` high from edge t+1 for one cycle.
- Minimum dwell per digit for a capture: `STABLE` cycles. Shorter dwells (ghosting during scan transitions) are ignored.
- Throughput: one capture per dwell. A fully scanned display yields one frame per `DIGITS` dwells.

## Test plan
1. **Reset.** Assert `iRst` → `oDigits`=FFFFFFFF, `oBlank`=00, `oErr`=0, no pulses. Deassert, then hold `iAn`=FF → no capture for 50 cycles.
2. **Full scan, defaults.** Scan digits 0..7 showing 0,1,2,3,4,5,6,7 with a 4-cycle dwell each → one `oFrameValid` pulse one cycle after digit 7's capture, `oDigits`=76543210, `oErr`=0. A second identical scan produces a second pulse.
3. **Blank and invalid digits.** Digit 3 = 1111111 and digit 5 = 0101010, other digits show 9 → `oDigits`=99E9F999, `oBlank`=08, `oErr`=1.
4. **Glitch rejection.** 1-cycle dwells with `STABLE`=2 → no capture. A digit changed mid-dwell is captured with its new value only after 2 stable samples.
5. **Anode fault.** `iAn`=FC for 1 cycle → `oAnErr` pulses once, run counter clears, and no slot is written from that sample.
6. **Reset mid-frame and overwrite.** Capture digits 0..3, assert `iRst`, then scan 0..7 → exactly one frame, matching only the post-reset values. Separately, recapture digit 2 as 8 before frame completion → the frame shows 8 at `[11:8]`.
